// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one inverse round per clock, round keys fetched by index.
// Optional macro AES_INV_CIPHER_PIPE_READY_EN lets a new block be accepted in DONE.

module inv_shift_rows (
  input  logic [127:0] blk,
  output logic [127:0] res
);
  // Row r of column c comes from column (c - r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign res[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end
endmodule

module inv_sub_bytes (
  input  logic [127:0] blk,
  output logic [127:0] res
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^-1 in GF(2^8); zero maps to zero.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign res[8*i +: 8] = inv_sbox(blk[8*i +: 8]);
  end
endmodule

module inv_mix_columns (
  input  logic [127:0] blk,
  output logic [127:0] res
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = blk[127-32*c -: 32];
    assign res[127-32*c -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  end
endmodule

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] NR_M1  = 4'(NR - 1);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] sr, sb, ark, mc;

  inv_shift_rows  u_isr (.blk(st),  .res(sr));
  inv_sub_bytes   u_isb (.blk(sr),  .res(sb));
  assign ark = sb ^ rk_data;
  inv_mix_columns u_imc (.blk(ark), .res(mc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      st  <= '0;
      rnd <= '0;
    end else begin
      fsm <= fsm_nxt;
      st  <= st_nxt;
      rnd <= rnd_nxt;
    end
  end

  // in_ready is forced low while reset is held, even though fsm already reads IDLE.
`ifdef AES_INV_CIPHER_PIPE_READY_EN
  assign in_ready = rst_n && ((fsm == IDLE) || (fsm == DONE && out_ready));
`else
  assign in_ready = rst_n && (fsm == IDLE);
`endif

  assign busy     = (fsm != IDLE);
  assign out_data = st;

  always_comb begin
    fsm_nxt   = fsm;
    st_nxt    = st;
    rnd_nxt   = rnd;
    rk_idx    = 4'd0;
    out_valid = 1'b0;
    case (fsm)
      IDLE: begin
        if (in_valid) begin
          st_nxt  = in_data;
          fsm_nxt = INIT;
        end
      end
      INIT: begin
        rk_idx  = NR_IDX;
        st_nxt  = st ^ rk_data;
        rnd_nxt = NR_M1;
        fsm_nxt = ROUND;
      end
      ROUND: begin
        rk_idx = rnd;
        st_nxt = mc;
        if (rnd == 4'd1) fsm_nxt = FINAL;
        else             rnd_nxt = rnd - 4'd1;
      end
      FINAL: begin
        st_nxt  = ark;
        fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef AES_INV_CIPHER_PIPE_READY_EN
        if (in_valid && out_ready) begin
          st_nxt  = in_data;
          fsm_nxt = INIT;
        end else if (out_ready) begin
          fsm_nxt = IDLE;
        end
`else
        if (out_ready) fsm_nxt = IDLE;
`endif
      end
      default: fsm_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: NR=10 and NR=14 instances served by a model key store.
module tb_aes_inv_cipher_iter;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_INV_CIPHER_PIPE_READY_EN
  localparam int B2B = 12;
`else
  localparam int B2B = 13;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid [2];
  logic         in_ready [2];
  logic [127:0] in_data  [2];
  logic [3:0]   rk_idx   [2];
  logic [127:0] rk_data  [2];
  logic         out_valid[2];
  logic         out_ready[2];
  logic [127:0] out_data [2];
  logic         busy     [2];

  logic [127:0] rk_tab [2][16];
  logic         noise;
  logic [127:0] rk_noise;

  assign rk_data[0] = noise ? rk_noise : rk_tab[0][rk_idx[0]];
  assign rk_data[1] = rk_tab[1][rk_idx[1]];

  aes_inv_cipher_iter #(.NR(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]));

  aes_inv_cipher_iter #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [127:0] data; int acc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic pv[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Forward S-box model for the key schedule.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b = 8'h01;
    for (int i = 0; i < 254; i++) b = gm(b, a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  task automatic expand(input int d, input logic [255:0] key, input int nk);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_tab[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_tab[d][15] = '0;
  endtask

  task automatic push_exp(input int d, input logic [127:0] data, input int acc);
    exp_t e;
    e.data = data;
    e.acc  = acc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called right after a posedge; in_valid is left high for the caller to drop.
  task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp_pt,
                      output int acc);
    int n = 0;
    acc = -1;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    forever begin
      @(negedge clk);
      if (in_ready[d]) break;
      n++;
      if (n > 200) begin
        fail_now("send_accept");
        in_valid[d] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    push_exp(d, exp_pt, acc);
  endtask

  task automatic wait_out(input int d);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid[d]) return;
    end
    fail_now("wait_out_valid");
  endtask

  task automatic mon(input int d);
    exp_t e;
    bit   have;
    if (!rst_n) begin
      pv[d] = 1'b0;
      return;
    end
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (out_valid[d] && !pv[d]) begin
      if (!have) fail_now("sb_unexpected_valid");
      else       chki(d == 0 ? "latency_nr10" : "latency_nr14", cyc - e.acc, d == 0 ? 11 : 15);
    end
    if (out_valid[d] && out_ready[d]) begin
      if (!have) begin
        fail_now("sb_unexpected_output");
      end else begin
        chk(d == 0 ? "out_data_nr10" : "out_data_nr14", out_data[d], e.data);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
    pv[d] = out_valid[d];
  endtask

  initial begin
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2;
    bit found;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
    noise = 1'b0;
    rk_noise = '0;
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chkb("rst_in_ready", in_ready[d], 1'b0);
      chkb("rst_out_valid", out_valid[d], 1'b0);
      chkb("rst_busy", busy[d], 1'b0);
      chk("rst_out_data", out_data[d], '0);
      chki("rst_rk_idx", int'(rk_idx[d]), 0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1 with round-key index sequence
    send(0, CT1, PT, a1);
    in_valid[0] = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      chki("c1_rk_idx", int'(rk_idx[0]), 10 - i);
    end
    wait_out(0);
    @(posedge clk);
    #1;

    // FIPS-197 C.3
    send(1, CT3, PT, a1);
    in_valid[1] = 1'b0;
    wait_out(1);
    @(posedge clk);
    #1;

    // Idle noise on rk_data and out_ready
    noise = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      rk_noise = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      chkb("idle_busy", busy[0], 1'b0);
      chkb("idle_out_valid", out_valid[0], 1'b0);
      chki("idle_rk_idx", int'(rk_idx[0]), 0);
      chk("idle_state", out_data[0], PT);
    end
    noise = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure with a competing block offered
    out_ready[0] = 1'b0;
    send(0, CT1, PT, a1);
    in_data[0] = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    wait_out(0);
    repeat (20) begin
      @(negedge clk);
      chkb("bp_out_valid", out_valid[0], 1'b1);
      chk("bp_out_data", out_data[0], PT);
      chkb("bp_in_ready", in_ready[0], 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chkb("bp_in_ready_after", in_ready[0], 1'b1);
    chkb("bp_busy_after", busy[0], 1'b0);
    @(posedge clk);
    #1;

    // Reset while in ROUND with rnd=5
    send(0, CT1, PT, a1);
    in_valid[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (busy[0] && rk_idx[0] == 4'd5) found = 1'b1;
    end
    if (!found) fail_now("reach_round5");
    #2 rst_n = 1'b0;
    #1;
    chkb("mid_rst_out_valid", out_valid[0], 1'b0);
    chkb("mid_rst_busy", busy[0], 1'b0);
    chk("mid_rst_out_data", out_data[0], '0);
    chkb("mid_rst_in_ready", in_ready[0], 1'b0);
    chki("mid_rst_rk_idx", int'(rk_idx[0]), 0);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, CT1, PT, a1);
    in_valid[0] = 1'b0;
    wait_out(0);
    @(posedge clk);
    #1;

    // Back-to-back blocks with in_valid held high
    send(0, CT1, PT, a1);
    send(0, CT1, PT, a2);
    in_valid[0] = 1'b0;
    chki("b2b_accept_spacing", a2 - a1, B2B);
    wait_out(0);
    repeat (2) @(posedge clk);
    #1;

    chki("sb_pending_nr10", q0.size(), 0);
    chki("sb_pending_nr14", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse cipher datapath: one inverse round per clock, driven by an internal FSM.
- Accepts one 128-bit ciphertext block over a valid/ready handshake and fetches round keys from the external key store by index.
- Instantiates the team's inv_shift_rows, inv_sub_bytes and inv_mix_columns stages.
- Returns the plaintext over a valid/ready handshake.

Parameters:
- NR, 10, number of rounds. Legal values 10, 12, 14 (AES-128/192/256). Any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ciphertext block offered.
- in_ready  output  1  block accepted on the edge where in_valid && in_ready.
- in_data  input  128  ciphertext; byte 0 in [127:120], column-major (column 0 = [127:96]).
- rk_idx  output  4  round-key index requested this cycle.
- rk_data  input  128  round key for rk_idx. Combinational from key store, valid in the same cycle.
- out_valid  output  1  plaintext available.
- out_ready  input  1  consumer accepts on the edge where out_valid && out_ready.
- out_data  output  128  plaintext, same byte order as in_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Registers:
  - st: 128-bit state register.
  - rnd: 4-bit round counter.
  - fsm: IDLE, INIT, ROUND, FINAL, DONE.
- Reset (async, rst_n low): fsm=IDLE, st=0, rnd=0, in_ready=0 during reset, out_valid=0, out_data=0, busy=0, rk_idx=0.
- IDLE:
  - in_ready=1.
  - On in_valid: st<=in_data, go INIT.
- INIT:
  - rk_idx=NR.
  - st<=st^rk_data; rnd<=NR-1; go ROUND.
- ROUND:
  - rk_idx=rnd.
  - st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^rk_data).
  - If rnd==1, go FINAL; else rnd<=rnd-1.
- FINAL:
  - rk_idx=0.
  - st<=InvSubBytes(InvShiftRows(st))^rk_data; go DONE.
- DONE:
  - out_valid=1; out_data=st.
  - On out_ready: go IDLE.
- rk_idx is combinational from fsm/rnd; 0 in IDLE and DONE.
- Latency: out_valid rises NR+1 edges after the accept edge (11 for NR=10, 15 for NR=14).
- Base throughput: one block per NR+3 cycles.
- in_ready=0 in every state except IDLE. in_valid and in_data are ignored (not sampled) while in_ready=0.
- out_data and out_valid are stable while out_valid && !out_ready. out_data may hold the last result in other states. Consumers sample only on out_valid.
- rk_data is sampled only in INIT/ROUND/FINAL. Its value in other states is don't-care.
- out_data is driven directly from st (no extra output register).
- Reset asserted mid-operation: the in-flight block is discarded and all outputs return to reset values immediately. After release, the FSM starts in IDLE.
- No X propagation: st is written only with defined values.

Optional Feature:
- Macro: AES_INV_CIPHER_PIPE_READY_EN.
- Defined:
  - in_ready = (fsm==IDLE) || (fsm==DONE && out_ready).
  - A new block accepted in DONE loads st and goes directly to INIT, giving back-to-back throughput of one block per NR+2 cycles.
  - out_data of the completed block is consumed on that same edge.
- Undefined:
  - in_ready is high only in IDLE, as above.
  - No combinational path from out_ready to in_ready.

Test Plan:
- FIPS-197 C.1, NR=10:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; bench serves expanded key of 000102030405060708090a0b0c0d0e0f.
  - Response: out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 edges after accept.
  - rk_idx sequence is 10,9,...,1,0.
- FIPS-197 C.3, NR=14:
  - Stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089; key 000102...1e1f.
  - Response: out_data 00112233445566778899aabbccddeeff, latency 15.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Response: out_data stable, in_ready=0 throughout, a second in_valid is not consumed; result accepted when out_ready=1, then in_ready=1 the next cycle.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 in ROUND with rnd=5.
  - Response: out_valid=0, busy=0, out_data=0 without a clock edge.
  - Follow-up: a fresh C.1 block after release decrypts correctly.
- Back-to-back blocks:
  - Stimulus: two C.1 blocks, in_valid held high, out_ready=1.
  - Without macro: second accept 13 cycles after the first.
  - With AES_INV_CIPHER_PIPE_READY_EN: 12 cycles.
  - Both outputs are correct.
- Idle noise:
  - Stimulus: randomise rk_data and out_ready while IDLE.
  - Response: busy=0, out_valid=0, rk_idx=0, st unchanged.
